// File: rtl/branch_predictor_2bit.sv
// branch_predictor_2bit: 2-bit saturating-counter direction predictor with direct-mapped BTB and branch/mispredict counters
module branch_predictor_2bit #(
  parameter int ENTRIES = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_IF,
  output logic        pred_taken_o,
  output logic [31:0] pred_pc_o,
  input  logic        upd_en_i,
  input  logic [31:0] pc_EX,
  input  logic        taken_i,
  input  logic [31:0] target_i,
  input  logic        mispred_i,
  output logic [31:0] br_cnt_o,
  output logic [31:0] mispred_cnt_o
);
  localparam int IDX = $clog2(ENTRIES);
  logic [ENTRIES-1:0] valid;
  logic [29-IDX:0]    tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];
  logic [IDX-1:0]     idx_f, idx_e;
  logic               hit_f, hit_e;
  logic               unused;
  assign unused       = ^{pc_IF[1:0], pc_EX[1:0]};
  assign idx_f        = pc_IF[IDX+1:2];
  assign idx_e        = pc_EX[IDX+1:2];
  assign hit_f        = valid[idx_f] && tag[idx_f] == pc_IF[31:IDX+2];
  assign hit_e        = valid[idx_e] && tag[idx_e] == pc_EX[31:IDX+2];
  assign pred_taken_o = hit_f && ctr[idx_f][1];
  assign pred_pc_o    = pred_taken_o ? target[idx_f] : pc_IF + 32'd4;
  // tags and targets are left unreset; valid=0 masks them
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid         <= '0;
      br_cnt_o      <= '0;
      mispred_cnt_o <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (upd_en_i) begin
      br_cnt_o      <= br_cnt_o + 32'd1;
      mispred_cnt_o <= mispred_cnt_o + {31'd0, mispred_i};
      if (hit_e) begin
        ctr[idx_e] <= taken_i ? (ctr[idx_e] == 2'b11 ? 2'b11 : ctr[idx_e] + 2'd1)
                              : (ctr[idx_e] == 2'b00 ? 2'b00 : ctr[idx_e] - 2'd1);
        if (taken_i) target[idx_e] <= target_i;
      end else if (taken_i) begin
        valid[idx_e]  <= 1'b1;
        tag[idx_e]    <= pc_EX[31:IDX+2];
        target[idx_e] <= target_i;
        ctr[idx_e]    <= 2'b10;
      end
    end
  end
endmodule

// File: doc/branch_predictor_2bit.md
# branch_predictor_2bit

Two-bit saturating-counter branch predictor with a direct-mapped branch target buffer (BTB). It sits in IF: for the current fetch PC it supplies the predicted next PC that travels down the pipe as `pc_ID`. It is trained from EX with the resolved direction and target of each control-transfer instruction, and it also counts resolved branches and mispredictions (the `comp_o` flag from hazard detection).

## Interface
- `ENTRIES`, 32: number of BTB/counter entries; power of two, 2..256. `IDX = log2(ENTRIES)`.
- `clk_i`  in  1  clock; everything updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `pc_IF`  in  32  current fetch PC (word aligned).
- `pred_taken_o`  out  1  prediction for `pc_IF` is taken.
- `pred_pc_o`  out  32  predicted next PC for `pc_IF`.
- `upd_en_i`  in  1  EX holds a control-transfer instruction (`op_ex[6:4] == 3'b110`); train this cycle.
- `pc_EX`  in  32  PC of the instruction being trained.
- `taken_i`  in  1  resolved direction (`PCSel_EX`).
- `target_i`  in  32  resolved target (ALU result).
- `mispred_i`  in  1  misprediction flag (`comp_o`); only sampled when `upd_en_i` = 1.
- `br_cnt_o`  out  32  number of resolved control transfers since reset.
- `mispred_cnt_o`  out  32  number of mispredictions since reset.

## Operation
- Each entry holds `valid`, `tag` = pc[31:IDX+2], `target[31:0]` and `ctr[1:0]`. The entry index is pc[IDX+1:2].
- Lookup is combinational from the stored state:
  - hit = `valid[idx]` && tag match on `pc_IF`.
  - `pred_taken_o` = hit && `ctr[1]`.
  - `pred_pc_o` = `pred_taken_o` ? `target[idx]` : `pc_IF + 4`. The +4 is modulo 2^32, so 0xFFFFFFFC wraps to 0x0.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Update on a clock edge with `upd_en_i` = 1, indexed by `pc_EX`:
  - **Hit:**
    - `ctr` increments if taken, decrements if not taken, saturating at 11 and 00.
    - If taken, `target` is overwritten with `target_i`.
  - **Miss and taken:** allocate or replace the entry. Set `valid` = 1, tag from `pc_EX`, `target` = `target_i`, `ctr` = 10.
  - **Miss and not taken:** no state change.
- Counters:
  - `br_cnt_o` increments on every `upd_en_i`.
  - `mispred_cnt_o` increments when `upd_en_i && mispred_i`.
  - Both wrap from 0xFFFFFFFF to 0.
- When `upd_en_i` = 0, all state holds; `taken_i`, `target_i` and `mispred_i` are ignored.
- Stalls and flushes are handled outside this block. The pipeline deasserts `upd_en_i` for bubbles, and a held `pc_IF` simply repeats the same lookup.

## Timing
- Lookup latency is 0 cycles: the outputs follow `pc_IF` combinationally within the same cycle.
- An update takes effect at the clock edge it is sampled on and becomes visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents. There is no bypass.
- Reset (synchronous, any cycle, including mid-training):
  - All `valid` = 0 and all `ctr` = 01.
  - `br_cnt_o` = 0 and `mispred_cnt_o` = 0.
  - Tags and targets do not need reset.
  - From the next cycle `pred_taken_o` = 0 and `pred_pc_o` = `pc_IF + 4`.
  - An update presented in the reset cycle is discarded.
- Aliasing: two PCs with the same index but different tags evict each other. Only a taken miss replaces an entry.

## Test plan
All scenarios use `ENTRIES` = 32.
1. **Reset state:** assert `rst_i` for 1 cycle, then drive `pc_IF` = 0x100 -> `pred_taken_o` = 0, `pred_pc_o` = 0x104, `br_cnt_o` = 0, `mispred_cnt_o` = 0.
2. **Taken allocate:** update `pc_EX` = 0x100, taken, `target_i` = 0x200, `mispred_i` = 1 -> in the same cycle, lookup of 0x100 still gives 0x104. Next cycle it gives `pred_taken_o` = 1 and `pred_pc_o` = 0x200; `br_cnt_o` = 1 and `mispred_cnt_o` = 1.
3. **Hysteresis:** from scenario 2 (ctr = 10), one not-taken update at 0x100 -> `pred_pc_o` = 0x104. A second not-taken update leaves ctr = 00. Two taken updates with `target_i` = 0x240 are then needed before the prediction returns 0x240.
4. **Saturation:** four taken updates at 0x100 (ctr = 11), then one not-taken -> still predicts taken (ctr = 10). Two further not-taken updates -> predicts not-taken, and the entry stays valid.
5. **Aliasing:**
   - With 0x100 allocated, look up 0x180 (same index, different tag) -> miss, `pred_pc_o` = 0x184.
   - A not-taken update at 0x180 -> 0x100 still hits.
   - A taken update at 0x180 with target 0x300 -> 0x180 predicts 0x300, and 0x100 now predicts 0x104.
6. **Reset mid-run and wrap:**
   - Assert `rst_i` in the same cycle as a taken update at 0x100 -> the next cycle predicts 0x104 and the counters read 0.
   - Lookup at 0xFFFFFFFC after reset -> `pred_pc_o` = 0x0.
